// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like multi-master arbiter.
//   - Default parameter values for the arbiter and its interface.
//   - Channel index constants for the CPU's fixed channel assignment.
//   - Width helpers. A response FIFO entry is packed as {id, data}:
//     id sits in [IDW+DW-1:DW] and data in [DW-1:0].
package sram_like_pkg;

  localparam int NCH_DEF   = 2;
  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;

  localparam int CH_IF   = 0;  // instruction fetch
  localparam int CH_DATA = 1;  // EXE-stage load/store

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Channel id width; kept at least 1 bit so NCH=1 still has a legal vector.
  function automatic int id_width(input int nch);
    return (nch > 1) ? clog2(nch) : 1;
  endfunction

  function automatic int resp_width(input int nch, input int dw);
    return id_width(nch) + dw;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the per-channel sram-like handshakes and the shared SRAM port.
//   ch_req/ch_wr/ch_wstrb/ch_addr/ch_wdata : masters -> arbiter
//   ch_addr_ok/ch_data_ok/ch_rdata         : arbiter -> masters
//   ch_resp_ready                          : masters -> arbiter
//   mem_en/mem_we/mem_addr/mem_wdata       : arbiter -> SRAM
//   mem_rdata                              : SRAM -> arbiter (1 cycle after mem_en)
// The master modport is the environment side (masters plus SRAM), the slave
// modport is the arbiter.
interface sram_like_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  localparam int SW = DW / 8;

  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_wr;
  logic [NCH*SW-1:0] ch_wstrb;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_addr_ok;
  logic [NCH-1:0]    ch_data_ok;
  logic [NCH*DW-1:0] ch_rdata;
  logic [NCH-1:0]    ch_resp_ready;
  logic              mem_en;
  logic [SW-1:0]     mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  modport master (
    output ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata, ch_resp_ready, mem_rdata,
    input  ch_addr_ok, ch_data_ok, ch_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata, ch_resp_ready, mem_rdata,
    output ch_addr_ok, ch_data_ok, ch_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sram_like_resp_fifo.sv
// Synchronous FIFO holding completed responses until the owning master takes them.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and count)
//   push       : write push_data this cycle (ignored when full)
//   pop        : drop the head entry this cycle (ignored when empty)
//   pop_data   : current head entry, valid while !empty
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);
  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define which entries
  // are live, so clearing the array would just cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state always uses <= so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits and wrap on their own.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Round-robin front end letting NCH sram-like masters share one SRAM port
// whose read data returns one cycle after mem_en.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : channel handshakes and SRAM port (see sram_like_arbiter_if)
// A grant at cycle T issues the SRAM access, T+1 captures its result into the
// response FIFO, and data_ok is raised from T+2 onward until the owner is ready.
// Responses leave strictly in acceptance order, so a stalled head blocks all.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic                clk,
  input logic                resetn,
  sram_like_arbiter_if.slave bus
);
  localparam int SW  = DW / 8;
  localparam int IDW = id_width(NCH);
  localparam int RW  = resp_width(NCH, DW);
  localparam int FCW = clog2(DEPTH) + 1;
  localparam int CW  = FCW + 1;

  logic [IDW-1:0] rr;
  logic [IDW-1:0] rr_next;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] gnt_id;
  logic           gnt_found;
  logic           can_accept;
  logic           grant;

  logic           fl_valid;
  logic [IDW-1:0] fl_id;
  logic           fl_wr;

  logic [RW-1:0]  push_data;
  logic [RW-1:0]  head;
  logic [IDW-1:0] head_id;
  logic [DW-1:0]  head_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic           pop;
  logic [CW-1:0]  cnt;

  // Credit is taken from registered state only: a pop this cycle frees its
  // slot for the next cycle, which keeps the credit path off the ready inputs.
  assign cnt        = CW'(fifo_count) + CW'(fl_valid);
  assign can_accept = (cnt < CW'(DEPTH));

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int off = 0; off < NCH; off++) begin
      cand = IDW'((int'(rr) + off) % NCH);
      if (!gnt_found && bus.ch_req[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Gating with resetn keeps addr_ok/mem_en low for the whole reset window,
  // not just from the next clock edge.
  assign grant   = resetn && gnt_found && can_accept;
  assign rr_next = (gnt_id == IDW'(NCH - 1)) ? '0 : gnt_id + 1'b1;

  assign bus.ch_addr_ok = grant ? (NCH'(1) << gnt_id) : '0;
  assign bus.mem_en     = grant;
  assign bus.mem_addr   = bus.ch_addr[gnt_id*AW +: AW];
  assign bus.mem_wdata  = bus.ch_wdata[gnt_id*DW +: DW];
  assign bus.mem_we     = (grant && bus.ch_wr[gnt_id]) ? bus.ch_wstrb[gnt_id*SW +: SW] : '0;

  // In-flight slot: the one access whose SRAM data arrives next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr       <= '0;
      fl_valid <= 1'b0;
      fl_id    <= '0;
      fl_wr    <= 1'b0;
    end else begin
      fl_valid <= grant;
      if (grant) begin
        rr    <= rr_next;
        fl_id <= gnt_id;
        fl_wr <= bus.ch_wr[gnt_id];
      end
    end
  end

  // Writes complete with zero data so every access gets exactly one data_ok.
  assign push_data = {fl_id, (fl_wr ? DW'(0) : bus.mem_rdata)};

  sram_like_resp_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (fl_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_id   = head[DW +: IDW];
  assign head_data = head[DW-1:0];

  assign bus.ch_data_ok = fifo_empty ? '0 : (NCH'(1) << head_id);
  assign bus.ch_rdata   = {NCH{head_data}};
  assign pop            = !fifo_empty && bus.ch_resp_ready[head_id];

  // Credit accounting must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!resetn) fl_valid |-> (!fifo_full || pop));

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter (NCH=2, DEPTH=4, 32-bit bus).
// Masters are request queues per channel; a reference model tracks accepted
// transactions as a queue with a visibility cycle, predicts grants from a
// round-robin pointer and credit, and keeps its own copy of memory contents.
module tb_sram_like_arbiter;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          vis;
  } resp_t;

  logic clk;
  logic resetn;

  sram_like_arbiter_if #(.NCH(NCH), .AW(32), .DW(32)) bus ();

  sram_like_arbiter #(
    .NCH   (NCH),
    .AW    (32),
    .DW    (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int model_rr = 0;
  bit rand_mode = 0;
  logic [NCH-1:0] ready;

  req_t  pend [NCH][$];
  resp_t mq[$];
  logic [31:0] sram    [int];
  logic [31:0] ref_mem [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h12345678 : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sram_rd(input int i);
    return sram.exists(i) ? sram[i] : init_word(i);
  endfunction

  function automatic logic [31:0] ref_rd(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
  endfunction

  // SRAM: read data one cycle after mem_en, garbage otherwise.
  always @(posedge clk) begin : sram_model
    int i;
    if (bus.mem_en) begin
      i = int'(bus.mem_addr[9:2]);
      bus.mem_rdata <= sram_rd(i);
      sram[i] = merge(sram_rd(i), bus.mem_wdata, bus.mem_we);
    end else begin
      bus.mem_rdata <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_req(input int ch, input logic wr, input logic [31:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
    pend[ch].push_back('{wr: wr, wstrb: wstrb, addr: addr, wdata: wdata});
  endtask

  task automatic gen_random();
    for (int c = 0; c < NCH; c++) begin
      if (pend[c].size() == 0 && $urandom_range(0, 99) < 60)
        add_req(c, ($urandom_range(0, 2) == 0), 32'($urandom_range(0, 63)) << 2,
                4'($urandom_range(1, 15)), $urandom);
      ready[c] = ($urandom_range(0, 99) < 75);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic check_cycle();
    int g;
    int i;
    req_t r;
    logic [NCH-1:0] exp_aok;
    logic [NCH-1:0] exp_dok;
    logic [31:0] d;
    g = -1;
    if (mq.size() < DEPTH)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && pend[(model_rr + k) % NCH].size() > 0) g = (model_rr + k) % NCH;
    exp_aok = '0;
    if (g >= 0) exp_aok[g] = 1'b1;
    check("addr_ok", bus.ch_addr_ok, exp_aok);
    check("mem_en", bus.mem_en, (g >= 0));
    if (g >= 0) begin
      r = pend[g][0];
      check("mem_addr", bus.mem_addr, r.addr);
      check("mem_we", bus.mem_we, r.wr ? r.wstrb : 4'h0);
      if (r.wr) check("mem_wdata", bus.mem_wdata, r.wdata);
    end else begin
      check("mem_we_idle", bus.mem_we, 4'h0);
    end
    exp_dok = '0;
    if (mq.size() > 0 && mq[0].vis <= cyc) exp_dok[mq[0].id] = 1'b1;
    check("data_ok", bus.ch_data_ok, exp_dok);
    if (exp_dok != '0) begin
      check("rdata", bus.ch_rdata[mq[0].id*32 +: 32], mq[0].data);
      if (ready[mq[0].id]) void'(mq.pop_front());
    end
    if (g >= 0) begin
      void'(pend[g].pop_front());
      i = int'(r.addr[9:2]);
      d = r.wr ? 32'h0 : ref_rd(i);
      if (r.wr) ref_mem[i] = merge(ref_rd(i), r.wdata, r.wstrb);
      mq.push_back('{id: g, data: d, vis: cyc + 2});
      model_rr = (g + 1) % NCH;
    end
  endtask

  task automatic cycle();
    logic [NCH-1:0]    rq;
    logic [NCH-1:0]    wrv;
    logic [NCH*4-1:0]  sb;
    logic [NCH*32-1:0] av;
    logic [NCH*32-1:0] dv;
    @(posedge clk);
    #1;
    if (rand_mode) gen_random();
    rq = '0; wrv = '0; sb = '0;
    for (int c = 0; c < NCH; c++) begin
      av[c*32 +: 32] = $urandom;
      dv[c*32 +: 32] = $urandom;
      if (pend[c].size() > 0) begin
        rq[c]          = 1'b1;
        wrv[c]         = pend[c][0].wr;
        sb[c*4 +: 4]   = pend[c][0].wstrb;
        av[c*32 +: 32] = pend[c][0].addr;
        dv[c*32 +: 32] = pend[c][0].wdata;
      end
    end
    bus.ch_req        = rq;
    bus.ch_wr         = wrv;
    bus.ch_wstrb      = sb;
    bus.ch_addr       = av;
    bus.ch_wdata      = dv;
    bus.ch_resp_ready = ready;
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  // Reset asserted mid-cycle; outputs must drop without waiting for a clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_addr_ok", bus.ch_addr_ok, '0);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_mem_we", bus.mem_we, 4'h0);
    check("rst_data_ok", bus.ch_data_ok, '0);
    bus.ch_req = '0;
    mq.delete();
    for (int c = 0; c < NCH; c++) pend[c].delete();
    model_rr = 0;
    ready    = '1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int pops;
    resetn            = 1'b0;
    ready             = '1;
    bus.ch_req        = '0;
    bus.ch_wr         = '0;
    bus.ch_wstrb      = '0;
    bus.ch_addr       = '0;
    bus.ch_wdata      = '0;
    bus.ch_resp_ready = '1;
    do_reset();

    // Single read on ch0.
    add_req(0, 1'b0, 32'h1C000000, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k == 0) begin
        check("t1_addr_ok", bus.ch_addr_ok, 2'b01);
        check("t1_mem_en", bus.mem_en, 1'b1);
      end
      check("t1_data_ok", bus.ch_data_ok, (k == 2) ? 2'b01 : 2'b00);
      if (k == 2) check("t1_rdata", bus.ch_rdata[31:0], 32'h12345678);
    end

    // Both channels streaming reads: grants and responses alternate from ch0.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      add_req(0, 1'b0, 32'h40 + 32'(n) * 4, 4'h0, 32'h0);
      add_req(1, 1'b0, 32'h80 + 32'(n) * 4, 4'h0, 32'h0);
    end
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k < 8) check("t2_grant", bus.ch_addr_ok, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k >= 2) check("t2_resp", bus.ch_data_ok, (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // ch1 partial write.
    do_reset();
    add_req(1, 1'b1, 32'h100, 4'b0011, 32'hAABBCCDD);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k == 0) begin
        check("t3_we", bus.mem_we, 4'b0011);
        check("t3_wdata", bus.mem_wdata, 32'hAABBCCDD);
        check("t3_addr", bus.mem_addr, 32'h100);
      end
      check("t3_data_ok", bus.ch_data_ok, (k == 2) ? 2'b10 : 2'b00);
      if (k == 2) check("t3_rdata", bus.ch_rdata[63:32], 32'h0);
    end

    // Credit stall: five reads with ch0 not ready.
    do_reset();
    ready = 2'b10;
    pops  = 0;
    for (int n = 0; n < 5; n++) add_req(0, 1'b0, 32'h10 * 32'(n + 1), 4'h0, 32'h0);
    for (int k = 0; k < 15; k++) begin
      if (k == 8) ready = 2'b11;
      cycle();
      if (k < 4) check("t4_accept", bus.ch_addr_ok, 2'b01);
      else if (k <= 8) check("t4_held", bus.ch_addr_ok, 2'b00);
      else if (k == 9) check("t4_fifth", bus.ch_addr_ok, 2'b01);
      if (bus.ch_data_ok[0] && ready[0]) pops++;
    end
    check("t4_pops", 64'(pops), 64'd5);

    // Head blocking: ch1's response waits behind stalled ch0.
    do_reset();
    ready = 2'b10;
    add_req(0, 1'b0, 32'h20, 4'h0, 32'h0);
    add_req(1, 1'b0, 32'h24, 4'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 5) ready = 2'b11;
      cycle();
      if (k >= 2 && k <= 5) check("t5_blocked", bus.ch_data_ok[1], 1'b0);
      if (k == 6) check("t5_released", bus.ch_data_ok, 2'b10);
    end

    // Reset with three outstanding, then a fresh ch1 read.
    do_reset();
    ready = 2'b10;
    for (int n = 0; n < 4; n++) add_req(0, 1'b0, 32'h30 + 32'(n) * 4, 4'h0, 32'h0);
    repeat (3) cycle();
    do_reset();
    add_req(1, 1'b0, 32'h100, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k == 0) check("t6_grant", bus.ch_addr_ok, 2'b10);
      check("t6_data_ok", bus.ch_data_ok, (k == 2) ? 2'b10 : 2'b00);
    end

    // Randomized traffic against the model, then drain.
    do_reset();
    rand_mode = 1;
    repeat (3000) cycle();
    rand_mode = 0;
    ready = '1;
    repeat (20) cycle();
    check("drain_empty", 64'(mq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
